// File: rtl/systolic_acc_writer.sv
// systolic_acc_writer: deskews three column psum streams and read-modify-writes
// each aligned row into a row-addressed 3-lane accumulator buffer.
module systolic_acc_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_wr_en,
  input  logic [ADDR_W-1:0]     acc_wr_addr,
  input  logic                  acc_clear,
  input  logic [DATA_W-1:0]     psum_col0,
  input  logic [DATA_W-1:0]     psum_col1,
  input  logic [DATA_W-1:0]     psum_col2,
  input  logic [2:0]            vld_col,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [3*DATA_W-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  acc_busy,
  output logic                  ovf_flag,
  output logic                  skew_err
);
  localparam int RW = 3 * DATA_W;
  logic [DATA_W-1:0] p0a_q, p0a_d, p0b_q, p0b_d, p1a_q, p1a_d;
  logic              v0a_q, v0a_d, v0b_q, v0b_d, v1a_q, v1a_d;
  logic              wr_en_q, wr_en_d, cp_q, cp_d, ow_q, ow_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              va_q, va_d, owa_q, owa_d, vb_q, vb_d;
  logic [RW-1:0]     rowa_q, rowa_d, sumb_q, sumb_d;
  logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic              ovf_q, ovf_d, skew_q, skew_d, rd_valid_q, rd_valid_d;
  logic [RW-1:0]     rd_data_q, rd_data_d;
  logic [RW-1:0]     mem_q [DEPTH];
  logic              rise, aligned, skew_now, row_ow, ovf_now;
  logic [ADDR_W-1:0] row_addr;
  logic [RW-1:0]     base;
  always_comb begin
    p0a_d = psum_col0;
    v0a_d = vld_col[0];
    p0b_d = p0a_q;
    v0b_d = v0a_q;
    p1a_d = psum_col1;
    v1a_d = vld_col[1];
    wr_en_d = acc_wr_en;
    rise = acc_wr_en & ~wr_en_q;
    aligned = v0b_q & v1a_q & vld_col[2];
    skew_now = (v0b_q | v1a_q | vld_col[2]) & ~aligned;
    // a row aligned in the rising-edge cycle already belongs to the new burst
    row_addr = rise ? acc_wr_addr : ptr_q;
    row_ow = rise ? (cp_q | acc_clear) : ow_q;
    ptr_d = aligned ? row_addr + 1'b1 : row_addr;
    ow_d = row_ow;
    cp_d = ~rise & (cp_q | acc_clear);
    va_d = aligned;
    rowa_d = {psum_col2, p1a_q, p0b_q};
    addra_d = row_addr;
    owa_d = row_ow;
    // stage B's sum is not yet in memory, so a same-row successor must take it directly
    base = owa_q ? '0 : (vb_q && addrb_q == addra_q) ? sumb_q : mem_q[addra_q];
    sumb_d = '0;
    ovf_now = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sumb_d[i*DATA_W +: DATA_W] = base[i*DATA_W +: DATA_W] + rowa_q[i*DATA_W +: DATA_W];
      ovf_now |= va_q & (base[i*DATA_W+DATA_W-1] == rowa_q[i*DATA_W+DATA_W-1])
                      & (sumb_d[i*DATA_W+DATA_W-1] != base[i*DATA_W+DATA_W-1]);
    end
    vb_d = va_q;
    addrb_d = addra_q;
    ovf_d = (~acc_clear & ovf_q) | ovf_now;
    skew_d = (~acc_clear & skew_q) | skew_now;
    rd_valid_d = rd_en;
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0a_q <= '0;
      p0b_q <= '0;
      p1a_q <= '0;
      v0a_q <= 1'b0;
      v0b_q <= 1'b0;
      v1a_q <= 1'b0;
      wr_en_q <= 1'b0;
      cp_q <= 1'b0;
      ow_q <= 1'b0;
      ptr_q <= '0;
      va_q <= 1'b0;
      owa_q <= 1'b0;
      rowa_q <= '0;
      addra_q <= '0;
      vb_q <= 1'b0;
      sumb_q <= '0;
      addrb_q <= '0;
      ovf_q <= 1'b0;
      skew_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      p0a_q <= p0a_d;
      p0b_q <= p0b_d;
      p1a_q <= p1a_d;
      v0a_q <= v0a_d;
      v0b_q <= v0b_d;
      v1a_q <= v1a_d;
      wr_en_q <= wr_en_d;
      cp_q <= cp_d;
      ow_q <= ow_d;
      ptr_q <= ptr_d;
      va_q <= va_d;
      owa_q <= owa_d;
      rowa_q <= rowa_d;
      addra_q <= addra_d;
      vb_q <= vb_d;
      sumb_q <= sumb_d;
      addrb_q <= addrb_d;
      ovf_q <= ovf_d;
      skew_q <= skew_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (vb_q) mem_q[addrb_q] <= sumb_q;
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign acc_busy = va_q | vb_q;
  assign ovf_flag = ovf_q;
  assign skew_err = skew_q;
endmodule

// File: doc/systolic_acc_writer.md
# systolic_acc_writer

Downstream stage of the systolic array controller. It removes the diagonal skew from the three column partial-sum streams leaving the 3x3 array and accumulates each re-aligned row into a row-addressed accumulator buffer using read-modify-write. Write bursts are framed by the controller's accumulator handshake (`acc_wr_en`, `acc_wr_addr`, `acc_clear`). A host read port exposes results to the output and activation path.

## Interface
- `DATA_W`, 32: width of each column partial sum and accumulator lane (signed two's complement).
- `DEPTH`, 256: accumulator rows; each row holds 3 lanes.
- `ADDR_W`, 8: row address width; `DEPTH` = 2^`ADDR_W`.
- `clk`  in  1  the single clock of this block.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `acc_wr_en`  in  1  burst window. Its rising edge starts a burst.
- `acc_wr_addr`  in  ADDR_W  base row address, sampled on the `acc_wr_en` rising edge.
- `acc_clear`  in  1  arms overwrite mode for the next burst and clears sticky flags.
- `psum_col0/1/2`  in  DATA_W each  column partial sums. Column j arrives j cycles after column 0 for the same row.
- `vld_col[2:0]`  in  3  per-column valid, skewed the same way as the data.
- `rd_en`  in  1  host read request.
- `rd_addr`  in  ADDR_W  host read row.
- `rd_data`  out  3*DATA_W  {lane2, lane1, lane0}; reset value 0.
- `rd_valid`  out  1  `rd_data` is valid; reset value 0.
- `acc_busy`  out  1  a row is held in pipeline stage A or stage B; reset value 0.
- `ovf_flag`  out  1  sticky signed-overflow flag; reset value 0.
- `skew_err`  out  1  sticky column-misalignment flag; reset value 0.

## Operation
- **Deskew.**
  - Column 0 data and valid are delayed 2 cycles; column 1 is delayed 1 cycle; column 2 is not delayed.
  - Aligned valid = d2(`vld_col[0]`) & d1(`vld_col[1]`) & `vld_col[2]`.
  - If the three aligned valids disagree in any cycle, set `skew_err` and drop that row.
- **Burst control.**
  - A rising edge of `acc_wr_en` (high now, low in the previous cycle) does three things:
    - loads base and row pointer `ptr` from `acc_wr_addr`;
    - sets overwrite mode to `clear_pending`;
    - clears `clear_pending`.
  - `acc_clear` = 1 in any cycle sets `clear_pending`. This includes cycles inside an active burst; it then affects only the next burst.
  - If `acc_clear` is asserted in the same cycle as a rising edge, that burst uses overwrite mode.
- **Row addressing.**
  - Each aligned-valid row takes the current `ptr`, then `ptr` increments modulo `DEPTH`: 255 wraps to 0.
  - Aligned rows continue to be accepted after `acc_wr_en` falls (drain).
  - If an aligned row arrives in the same cycle as a rising edge, it uses the newly loaded base.
- **Pipeline.**
  - Stage A registers the aligned row and its address.
  - Stage B computes sum = (overwrite ? 0 : acc[addrA]) + row, lane-wise, and registers it.
  - The memory is written from stage B on the following edge.
- **Forwarding.** If stage B is valid and addrB == addrA, stage A reads stage B's sum instead of the memory.
- **Arithmetic.**
  - Per-lane sums wrap modulo 2^`DATA_W`.
  - Signed overflow in any lane sets `ovf_flag`. Overwrite writes cannot overflow.
- **Sticky flags.** `ovf_flag` and `skew_err` are cleared only by `acc_clear` or reset.
- **Host read.**
  - `rd_en` in cycle t gives `rd_data = acc[rd_addr]` with `rd_valid` = 1 in cycle t+1.
  - When a host read and a memory write hit the same row in the same cycle, the read returns the pre-write value.
  - While `rd_en` is 0, `rd_data` holds its last value.
- **Reset.**
  - Clears deskew registers, pipeline valids, `ptr`, `clear_pending`, flags and outputs.
  - Rows in flight are discarded.
  - Memory contents are not reset and are undefined until written in overwrite mode.

## Timing
- Latency: `vld_col[2]` sampled at edge k → stage A at edge k → stage B at edge k+1 → memory written at edge k+2.
- A host read issued in the cycle after edge k+2 returns the updated row.
- Throughput: one row per cycle, sustained, with no stall.
- `acc_busy` is high in any cycle where stage A or stage B holds a valid row.
- The block does not apply back-pressure. Upstream must present column 0 of row r+1 no earlier than one cycle after column 0 of row r.

## Test plan
- **Overwrite burst.**
  - Stimulus: pulse `acc_clear`, then a burst at `acc_wr_addr`=10 with rows {1,2,3} and {4,5,6}, correctly skewed.
  - Response: reading rows 10 and 11 returns {3,2,1} and {6,5,4}; `acc_busy` falls 3 cycles after the last `vld_col[2]`.
- **Accumulate.**
  - Stimulus: repeat the same burst without `acc_clear`.
  - Response: row 10 = {6,4,2} and row 11 = {12,10,8}.
- **Wrap and forwarding.**
  - Stimulus: overwrite burst at addr 255 with 2 rows, then an immediate new accumulate burst at addr 255.
  - Response: rows 255 and 0 are written, and the second burst's row 255 correctly includes the first burst's in-flight value.
- **Skew error.**
  - Stimulus: assert `vld_col[1]` one cycle late for one row.
  - Response: `skew_err` = 1, no memory write for that row, and later rows are unaffected. `acc_clear` clears the flag.
- **Overflow.**
  - Stimulus: accumulate 0x7FFFFFFF + 1 in lane 0.
  - Response: lane 0 = 0x80000000 and `ovf_flag` = 1.
- **Reset mid-burst.**
  - Stimulus: drop `rst_n` while stage B is valid.
  - Response: all outputs are 0 immediately, no write occurs, and the row pointer restarts on the next rising edge of `acc_wr_en`.
